keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD layout) by driving one column low at a time and reading the four rows back. Each press is debounced over whole scan frames and reported as a single-cycle `key_valid` strobe with a 4-bit hex `key_code`. This is the input-side counterpart of the seven-segment digit refresh path: time-multiplexed column drive in, instead of time-multiplexed digit drive out. Its outputs feed the same hex-digit datapath that the display shows.

## Interface
- `SCAN_DIV`, 16'd50000: clock cycles each column is held active. Legal range 4..65535.
- `DEBOUNCE_SCANS`, 4'd4: consecutive identical frames required to accept a press or a release. Legal range 1..15.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `row`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col`  out 4  keypad column drive, active-low one-hot.
- `key_code`  out 4  hex value of the last accepted key; held until the next accepted key.
- `key_valid`  out 1  one-cycle strobe when a press is accepted.
- `key_down`  out 1  high from acceptance of a press until acceptance of its release.

## Operation
- **Row input:** `row` passes through a 2-flop synchronizer before any use.
- **Column scan:**
  - `div` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the 2-bit `col_idx` increments 0→1→2→3→0.
  - `col = ~(4'b0001 << col_idx)`.
- **Row sampling:** synchronized rows are sampled when `div == SCAN_DIV-1`, the last cycle of the dwell. Row r is pressed in column c if `row_sync[r] == 0`.
- **Key map** (row r, column c), row 0: 1,2,3,A; row 1: 4,5,6,B; row 2: 7,8,9,C; row 3: 0,F,E,D.
- **Frame:**
  - One frame is columns 0..3, i.e. 4*SCAN_DIV cycles.
  - A frame accumulates its pressed-key count and the code of the first key found (column-major, lowest column, then lowest row).
  - The frame result is evaluated at the column-3 sample:
    - NONE if 0 keys pressed.
    - UNIQUE(code) if exactly 1 key pressed.
    - MULTI if 2 or more keys pressed.
- **FSM** (advances only at frame evaluation), with a 4-bit counter `cnt`:
  - **IDLE:**
    - UNIQUE(k): go to DEBOUNCE, `cand=k`, `cnt=1`. If DEBOUNCE_SCANS==1, accept immediately and go to PRESSED.
    - Otherwise: stay in IDLE.
  - **DEBOUNCE:**
    - UNIQUE(cand): `cnt++`. When `cnt` reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - Any other result (including a different key): return to IDLE.
  - **PRESSED:**
    - NONE: go to RELEASE, `cnt=1`. If DEBOUNCE_SCANS==1, release immediately and go to IDLE.
    - UNIQUE or MULTI: stay in PRESSED. No repeat strobe is ever generated.
  - **RELEASE:**
    - NONE: `cnt++`. When `cnt` reaches DEBOUNCE_SCANS, go to IDLE and clear `key_down`.
    - UNIQUE or MULTI: return to PRESSED.
- **Accept:** `key_code <= cand`, `key_valid <= 1` for one cycle, `key_down <= 1`.
- **Ghosting and rollover:** MULTI never produces a key. A second key pressed during a held key does not produce a new key until all keys are released.

## Timing
- **Reset values:** `col=4'b1110`, `div=0`, `col_idx=0`, FSM=IDLE, `cnt=0`, `key_code=4'h0`, `key_valid=0`, `key_down=0`, frame accumulators and synchronizer flops cleared.
- **First frame after reset** starts with column 0 at `div=0` on the cycle after `rst` deasserts.
- **Row-to-sample latency:** row change to synchronized row is 2 cycles. A sample therefore reflects `row` as of at least 2 cycles earlier, so SCAN_DIV≥4 guarantees settling after a column change.
- **Registered outputs:** `key_valid` and `key_down` are registered and assert/deassert the cycle after the frame-evaluation cycle.
- **Minimum press latency:** from the first frame containing the key to `key_valid` is DEBOUNCE_SCANS frames plus 1 cycle.
- **Reset mid-operation:** `rst` has priority over everything. All state returns to the reset values on the next edge, with no strobe. A key held through reset is re-debounced from IDLE.
- **Counter width:** `cnt` saturates logic at DEBOUNCE_SCANS, so it never wraps.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3 (frame = 16 cycles).

- **Column sequence:** release `rst`, no keys → `col` = 1110 for 4 cycles, then 1101, 1011, 0111, repeating. `key_valid`/`key_down` stay 0 for 20 frames.
- **Single press and release:** hold row 2 low whenever column 1 is active (key 8) from frame 0 → exactly one `key_valid` at frame-2 evaluation +1 cycle, `key_code=4'h8`, `key_down=1`. Release → `key_down` falls 3 frames later; `key_code` stays 8.
- **Bounce rejection:** key A (row 0, column 3) present for 2 frames, absent 1, present 2 → no `key_valid`.
- **Multi-key:** keys 1 and 5 held together for 10 frames → no `key_valid`. Release 5 (key 1 remains) → `key_valid` with `key_code=4'h1` after 3 frames.
- **Held key:** key D held 50 frames → a single `key_valid`. A 1-frame release glitch while PRESSED → `key_down` stays 1 and no second strobe.
- **Reset mid-debounce:** key 0 held, `rst` pulsed during frame 2 → no strobe. Outputs at reset values, `col=1110`. Strobe follows 3 frames after reset release.

Source files
------------

// File: rtl/keypad_scanner.sv
// Scans a 4x4 matrix keypad one active-low column at a time and debounces
// each press over whole scan frames into a one-cycle strobe plus a hex code.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t     state, state_nxt;
  logic [3:0] row_meta, row_sync;
  logic [15:0] div;
  logic [1:0] col_idx;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;
  logic [1:0] col_cnt;
  logic [1:0] first_row;
  logic [2:0] sum;
  logic [1:0] tot;
  logic [3:0] col_code, first_code;
  logic [3:0] cnt, cnt_nxt, cand, cand_nxt, key_code_nxt;
  logic       key_valid_nxt, key_down_nxt;
  logic [4:0] cnt_inc;
  logic       sample, frame_end, reached;
  logic       res_none, res_unique;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign col       = ~(4'b0001 << col_idx);
  assign sample    = (div == SCAN_DIV - 16'd1);
  assign frame_end = sample && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
      div      <= '0;
      col_idx  <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (sample) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        div <= div + 16'd1;
      end
    end
  end

  // Per-column hit count saturates at 2, since only none/one/many matters.
  always_comb begin
    col_cnt   = '0;
    first_row = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) first_row = 2'(r);
    end
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r] && col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
    end
    col_code   = key_map(first_row, col_idx);
    sum        = {1'b0, acc_cnt} + {1'b0, col_cnt};
    tot        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    first_code = (acc_cnt != 2'd0) ? acc_code : col_code;
    res_none   = (tot == 2'd0);
    res_unique = (tot == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      if (col_idx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt <= tot;
        if (acc_cnt == 2'd0) acc_code <= col_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_down  <= key_down_nxt;
    end
  end

  // Debounce FSM moves only at frame evaluation; outputs land one cycle later.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cand_nxt      = cand;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_down_nxt  = key_down;
    cnt_inc       = {1'b0, cnt} + 5'd1;
    reached       = (cnt_inc >= {1'b0, DEBOUNCE_SCANS});
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_unique) begin
            cand_nxt = first_code;
            cnt_nxt  = 4'd1;
            if (DEBOUNCE_SCANS == 4'd1) begin
              state_nxt     = PRESSED;
              key_code_nxt  = first_code;
              key_valid_nxt = 1'b1;
              key_down_nxt  = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (res_unique && first_code == cand) begin
            if (reached) begin
              state_nxt     = PRESSED;
              cnt_nxt       = DEBOUNCE_SCANS;
              key_code_nxt  = cand;
              key_valid_nxt = 1'b1;
              key_down_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc[3:0];
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (res_none) begin
            cnt_nxt = 4'd1;
            if (DEBOUNCE_SCANS == 4'd1) begin
              state_nxt    = IDLE;
              key_down_nxt = 1'b0;
            end else begin
              state_nxt = RELEASE;
            end
          end
        end
        default: begin
          if (res_none) begin
            if (reached) begin
              state_nxt    = IDLE;
              cnt_nxt      = '0;
              key_down_nxt = 1'b0;
            end else begin
              cnt_nxt = cnt_inc[3:0];
            end
          end else begin
            state_nxt = PRESSED;
          end
        end
      endcase
    end
  end

endmodule
